// File: rtl/l2_way_array.sv
// L2 way array: WAYS x 2**S_INDEX flop-based entries (WIDTH data bits + valid bit each).
// Reads are combinational at index. Writes go to the selected ways at the clock edge.
// A flush request starts a sweep that clears every set's valid bits, one set per cycle,
// with busy high. Data bits are never cleared by a flush, only by reset.
// Optional build macro: L2_WAY_ARRAY_BYPASS_EN forwards datain to dataout in the write cycle.
module l2_way_array #(
  parameter int unsigned S_INDEX = 3,
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned WAYS    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_INDEX-1:0]      index,
  input  logic [WAYS-1:0]         load,
  input  logic [WIDTH-1:0]        datain,
  output logic [WAYS*WIDTH-1:0]   dataout,
  output logic [WAYS-1:0]         valid,
  input  logic                    flush,
  output logic                    busy
);

  localparam int unsigned NumSets = 2 ** S_INDEX;
  localparam logic [S_INDEX-1:0] PtrLast = S_INDEX'(NumSets - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e               state_q, state_d;
  logic [S_INDEX-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]     data_q  [WAYS][NumSets];
  logic [NumSets-1:0]   valid_q [WAYS];

  assign busy = (state_q == StSweep);

  // Sweep control: IDLE waits for flush, SWEEP walks ptr to the last set and ends there.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          state_d = StSweep;
          ptr_d   = '0;
        end
      end
      StSweep: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PtrLast) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // State and sweep pointer registers; reset aborts any sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage update: writes only while idle; sweep clears valid of set ptr in every way.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        for (int s = 0; s < NumSets; s++) begin
          data_q[w][s] <= '0;
        end
      end
    end else if (!busy) begin
      for (int w = 0; w < WAYS; w++) begin
        if (load[w]) begin
          data_q[w][index]  <= datain;
          valid_q[w][index] <= 1'b1;
        end
      end
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w][ptr_q] <= 1'b0;
      end
    end
  end

  // Combinational read of set index, optionally forwarding an in-flight write.
  always_comb begin
    dataout = '0;
    valid   = '0;
    for (int w = 0; w < WAYS; w++) begin
      dataout[w*WIDTH +: WIDTH] = data_q[w][index];
      valid[w]                  = valid_q[w][index];
`ifdef L2_WAY_ARRAY_BYPASS_EN
      if (!busy && load[w]) begin
        dataout[w*WIDTH +: WIDTH] = datain;
        valid[w]                  = 1'b1;
      end
`endif
    end
  end

endmodule

// File: doc/l2_way_array.md
L2_WAY_ARRAY -- requirements
Module: l2_way_array

Interface
REQ-001 The block SHALL have parameter S_INDEX, 3, index width; NUM_SETS = 2**S_INDEX.
REQ-002 The block SHALL have parameter WIDTH, 1, data bits per way entry.
REQ-003 The block SHALL have parameter WAYS, 2, number of parallel ways (>= 1).
REQ-004 The block SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port index  input  S_INDEX  shared read/write set index.
REQ-007 The block SHALL have port load  input  WAYS  per-way write enable, bit w selects way w.
REQ-008 The block SHALL have port datain  input  WIDTH  write data, common to all selected ways.
REQ-009 The block SHALL have port dataout  output  WAYS*WIDTH  read data, way w at bits [w*WIDTH +: WIDTH].
REQ-010 The block SHALL have port valid  output  WAYS  per-way valid bit of set index.
REQ-011 The block SHALL have port flush  input  1  single-cycle request to invalidate all sets.
REQ-012 The block SHALL have port busy  output  1  high while the flush sweep runs.

Function
REQ-013 Storage SHALL be WAYS x NUM_SETS entries of WIDTH data bits plus 1 valid bit, built from flops (no inferred RAM).
REQ-014 Read SHALL be combinational: dataout/valid reflect entry contents at index in the same cycle, with zero added latency.
REQ-015 Write: with busy low and load[w]=1, the rising edge SHALL write datain to data[w][index] and set valid[w][index]=1.
REQ-016 Multiple load bits set together SHALL write all selected ways in the same cycle; unselected ways stay unchanged.
REQ-017 The FSM SHALL have exactly two states, IDLE and SWEEP; the reset state is IDLE.
REQ-018 IDLE -> SWEEP on flush=1; the sweep pointer SHALL load 0 and busy SHALL go high on the next cycle.
REQ-019 In SWEEP, each cycle SHALL clear valid[all ways][ptr] and increment ptr; data bits SHALL NOT be cleared.
REQ-020 SWEEP -> IDLE after clearing ptr = NUM_SETS-1; the sweep SHALL last exactly NUM_SETS cycles with busy high.
REQ-021 While busy=1, load SHALL be ignored (no data or valid change) and flush SHALL be ignored.
REQ-022 flush and load in the same IDLE cycle: the write SHALL complete, then the sweep SHALL invalidate it.
REQ-023 The ptr counter SHALL be S_INDEX bits wide; the terminal test SHALL use ptr == NUM_SETS-1, not wrap-around.
REQ-024 Reads during SWEEP SHALL remain legal and return current contents (already-swept sets read valid=0).

Reset
REQ-025 rst SHALL clear all data and valid bits to 0, set the state to IDLE, set ptr to 0 and drive busy to 0 on the next edge.
REQ-026 rst SHALL take priority over flush, load and an in-progress sweep (reset mid-sweep aborts to IDLE).
REQ-027 After reset, dataout = 0 and valid = 0 for every index.

Configuration
REQ-028 Macro L2_WAY_ARRAY_BYPASS_EN defined: for each way w with load[w]=1 and busy=0, dataout[w] SHALL equal datain and valid[w] SHALL equal 1 combinationally in the same cycle.
REQ-029 Macro L2_WAY_ARRAY_BYPASS_EN undefined: dataout/valid SHALL show stored contents only; the written value SHALL become visible on the cycle after the write edge.

Verification
REQ-030 The bench SHALL cover: reset, then read every index -> dataout=0, valid=0, busy=0.
REQ-031 The bench SHALL cover: WAYS=2, WIDTH=8, index=5, load=2'b10, datain=8'hA5 -> next cycle way1=8'hA5, valid=2'b10, way0 unchanged.
REQ-032 The bench SHALL cover: fill all sets, pulse flush -> busy high for exactly 8 cycles (S_INDEX=3), then all valid=0 and data retained.
REQ-033 The bench SHALL cover: load=2'b01 while busy -> no change to data or valid; flush while busy -> sweep length unchanged.
REQ-034 The bench SHALL cover: rst asserted on the 4th sweep cycle -> next cycle busy=0, all data=0.
REQ-035 The bench SHALL cover: with BYPASS_EN, load=2'b01 with datain=8'h3C -> dataout way0=8'h3C in the same cycle; without BYPASS_EN, 8'h3C appears the cycle after.
